// File: rtl/share_decoder.sv
// Consumer end of the masked AND gadget: requests one evaluation, captures the
// output shares on the done pulse and recombines them serially into one bit.
module share_decoder #(
   parameter int D       = 2,
   parameter int TIMEOUT = 15
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   output logic         and_enable,
   input  logic         and_done,
   input  logic [0:D-1] shares_in,
   output logic         result,
   output logic         result_valid,
   input  logic         result_ack,
   output logic         busy,
   output logic         timeout_err
);

   localparam int IDX_W = $clog2(D) + 1;
   localparam int SEL_W = $clog2(D);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_ACC  = 2'd2;
   localparam logic [1:0] S_HOLD = 2'd3;

   logic [1:0]       state;
   logic [0:D-1]     share_reg;
   logic [IDX_W-1:0] idx;
   logic [CNT_W-1:0] wait_cnt;
   logic             acc;
   logic             cur_share;

   // One share folded in per cycle so no two shares meet in the same logic level.
   assign cur_share = share_reg[idx[SEL_W-1:0]];
   assign busy      = (state != S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         and_enable   <= 1'b0;
         result       <= 1'b0;
         result_valid <= 1'b0;
         timeout_err  <= 1'b0;
         share_reg    <= '0;
         idx          <= '0;
         wait_cnt     <= '0;
         acc          <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               wait_cnt <= '0;
               if (start) begin
                  state       <= S_WAIT;
                  and_enable  <= 1'b1;
                  timeout_err <= 1'b0;
               end
            end
            S_WAIT: begin
               // A done arriving on the timeout edge still counts as a success.
               if (and_done) begin
                  share_reg  <= shares_in;
                  acc        <= 1'b0;
                  idx        <= '0;
                  and_enable <= 1'b0;
                  state      <= S_ACC;
               end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                  timeout_err <= 1'b1;
                  and_enable  <= 1'b0;
                  state       <= S_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_ACC: begin
               acc <= acc ^ cur_share;
               idx <= idx + 1'b1;
               if (idx == IDX_W'(D - 1)) begin
                  result       <= acc ^ cur_share;
                  result_valid <= 1'b1;
                  state        <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (result_ack) begin
                  result       <= 1'b0;
                  result_valid <= 1'b0;
                  state        <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_share_decoder.sv
// Bench for share_decoder: D=2 and D=3 instances driven by a directed gadget
// model, with a queue-based scoreboard checking every presented result.
module tb_share_decoder;

   logic       clk = 1'b0;
   logic       rst_n;

   logic       start2, done2, ack2;
   logic [0:1] sh2;
   logic       en2, res2, rv2, busy2, terr2;

   logic       start3, done3, ack3;
   logic [0:2] sh3;
   logic       en3, res3, rv3, busy3, terr3;

   int         vectors     = 0;
   int         miscompares = 0;
   logic       q2[$];
   logic       q3[$];
   logic       prev2 = 1'b0;
   logic       prev3 = 1'b0;
   logic [7:0] par_tbl = 8'b1001_0110;

   always #5 clk = ~clk;

   share_decoder #(.D(2), .TIMEOUT(15)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .and_enable(en2),
      .and_done(done2), .shares_in(sh2), .result(res2), .result_valid(rv2),
      .result_ack(ack2), .busy(busy2), .timeout_err(terr2)
   );

   share_decoder #(.D(3), .TIMEOUT(15)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .and_enable(en3),
      .and_done(done3), .shares_in(sh3), .result(res3), .result_valid(rv3),
      .result_ack(ack3), .busy(busy3), .timeout_err(terr3)
   );

   task automatic chk(input string name, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every rising result_valid must match the oldest expected result.
   always @(negedge clk) begin
      if (rv2 && !prev2) begin
         if (q2.size() == 0) chk("unexpected_valid_d2", rv2, 1'b0);
         else                chk("sb_result_d2", res2, q2.pop_front());
      end
      if (rv3 && !prev3) begin
         if (q3.size() == 0) chk("unexpected_valid_d3", rv3, 1'b0);
         else                chk("sb_result_d3", res3, q3.pop_front());
      end
      prev2 = rv2;
      prev3 = rv3;
   end

   // Returns at the negedge right after the start edge k.
   task automatic start_d2();
      @(negedge clk); start2 = 1'b1;
      @(negedge clk); start2 = 1'b0;
   endtask

   task automatic start_d3();
      @(negedge clk); start3 = 1'b1;
      @(negedge clk); start3 = 1'b0;
   endtask

   // Gadget model: done sampled at edge k+3; returns after edge k+3.
   task automatic gadget_d2(input logic [0:1] sh);
      chk("en_k_d2", en2, 1'b1);
      @(negedge clk); chk("en_k1_d2", en2, 1'b1);
      @(negedge clk); chk("en_k2_d2", en2, 1'b1);
      done2 = 1'b1; sh2 = sh;
      @(negedge clk); done2 = 1'b0; sh2 = '0;
      chk("en_off_d2", en2, 1'b0);
      chk("busy_acc_d2", busy2, 1'b1);
   endtask

   task automatic gadget_d3(input logic [0:2] sh);
      chk("en_k_d3", en3, 1'b1);
      @(negedge clk);
      @(negedge clk); done3 = 1'b1; sh3 = sh;
      @(negedge clk); done3 = 1'b0; sh3 = '0;
      chk("en_off_d3", en3, 1'b0);
   endtask

   task automatic finish_d2(input logic exp);
      @(negedge clk); chk("rv_early_d2", rv2, 1'b0);
      @(negedge clk); chk("rv_d2", rv2, 1'b1); chk("res_d2", res2, exp);
      ack2 = 1'b1;
      @(negedge clk); ack2 = 1'b0;
      chk("rv_clr_d2", rv2, 1'b0);
      chk("res_clr_d2", res2, 1'b0);
      chk("busy_clr_d2", busy2, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      rst_n  = 1'b0;
      start2 = 1'b0; done2 = 1'b0; ack2 = 1'b0; sh2 = '0;
      start3 = 1'b0; done3 = 1'b0; ack3 = 1'b0; sh3 = '0;
      @(negedge clk); @(negedge clk);
      chk("rst_en", en2, 1'b0);
      chk("rst_rv", rv2, 1'b0);
      chk("rst_res", res2, 1'b0);
      chk("rst_busy", busy2, 1'b0);
      chk("rst_terr", terr2, 1'b0);
      chk("rst_busy_d3", busy3, 1'b0);
      rst_n = 1'b1;

      // Shares 10 -> 1, valid after edge k+5.
      q2.push_back(1'b1);
      start_d2();
      chk("busy_wait_d2", busy2, 1'b1);
      gadget_d2(2'b10);
      finish_d2(1'b1);

      // Shares 11 -> 0, result held while ack stays low.
      q2.push_back(1'b0);
      start_d2();
      gadget_d2(2'b11);
      @(negedge clk); chk("rv_early2_d2", rv2, 1'b0);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk("hold_rv_d2", rv2, 1'b1);
         chk("hold_res_d2", res2, 1'b0);
         chk("hold_busy_d2", busy2, 1'b1);
         @(negedge clk);
      end
      ack2 = 1'b1;
      @(negedge clk); ack2 = 1'b0;
      chk("ack_rv_d2", rv2, 1'b0);
      chk("ack_busy_d2", busy2, 1'b0);

      // No done: abort after 15 WAIT edges.
      start_d2();
      for (int i = 2; i <= 15; i++) @(negedge clk);
      chk("to_pre_terr", terr2, 1'b0);
      chk("to_pre_en", en2, 1'b1);
      @(negedge clk);
      chk("to_terr", terr2, 1'b1);
      chk("to_en", en2, 1'b0);
      chk("to_busy", busy2, 1'b0);
      repeat (3) @(negedge clk);
      chk("to_sticky", terr2, 1'b1);
      chk("to_no_rv", rv2, 1'b0);
      q2.push_back(1'b1);
      start_d2();
      chk("to_clear", terr2, 1'b0);
      gadget_d2(2'b01);
      finish_d2(1'b1);

      // Spurious done in IDLE and start re-pulses in WAIT/ACC/HOLD.
      @(negedge clk); done2 = 1'b1; sh2 = 2'b11;
      @(negedge clk); done2 = 1'b0; sh2 = '0;
      chk("spur_busy", busy2, 1'b0);
      chk("spur_en", en2, 1'b0);
      q2.push_back(1'b1);
      start_d2();
      @(negedge clk); start2 = 1'b1;
      @(negedge clk); start2 = 1'b0; done2 = 1'b1; sh2 = 2'b01;
      @(negedge clk); done2 = 1'b0; sh2 = '0; start2 = 1'b1;
      @(negedge clk); start2 = 1'b0;
      @(negedge clk); chk("re_rv", rv2, 1'b1); chk("re_res", res2, 1'b1);
      start2 = 1'b1;
      @(negedge clk); ack2 = 1'b1;
      @(negedge clk); ack2 = 1'b0; start2 = 1'b0;
      chk("re_busy", busy2, 1'b0);
      chk("re_rv_clr", rv2, 1'b0);
      repeat (6) @(negedge clk);
      chk("re_idle", busy2, 1'b0);
      chk("re_en", en2, 1'b0);

      // Asynchronous reset in the middle of WAIT.
      start_d2();
      @(negedge clk);
      chk("ar_en_pre", en2, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_en", en2, 1'b0);
      chk("ar_busy", busy2, 1'b0);
      chk("ar_rv", rv2, 1'b0);
      @(negedge clk); rst_n = 1'b1;
      chk("ar_idle", busy2, 1'b0);
      q2.push_back(1'b1);
      start_d2();
      gadget_d2(2'b10);
      finish_d2(1'b1);

      // D=3: every share pattern against its parity.
      for (int p = 0; p < 8; p++) begin
         q3.push_back(par_tbl[p]);
         start_d3();
         gadget_d3(3'(p));
         @(negedge clk);
         @(negedge clk); chk("rv_early_d3", rv3, 1'b0);
         @(negedge clk); chk("rv_d3", rv3, 1'b1); chk("res_d3", res3, par_tbl[p]);
         ack3 = 1'b1;
         @(negedge clk); ack3 = 1'b0;
         chk("rv_clr_d3", rv3, 1'b0);
         chk("busy_clr_d3", busy3, 1'b0);
      end

      @(negedge clk);
      chk("sb_drained_d2", q2.size() == 0, 1'b1);
      chk("sb_drained_d3", q3.size() == 0, 1'b1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
